serial_bit_stream_tx: RTL and testbench



---
 rtl/serial_bit_stream_tx_if.sv | 33 +++
 rtl/serial_bit_stream_tx.sv | 106 ++++++++++
 tb/tb_serial_bit_stream_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_bit_stream_tx_if.sv
// Handshake bundle between a word source and the serial transmitter.
// master drives start/data_in; slave (transmitter) drives the serial outputs.
interface serial_bit_stream_tx_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic             exp_y;

    modport master (
        output start,
        output data_in,
        input  x_out,
        input  x_valid,
        input  busy,
        input  done,
        input  exp_y
    );

    modport slave (
        input  start,
        input  data_in,
        output x_out,
        output x_valid,
        output busy,
        output done,
        output exp_y
    );
endinterface

// File: rtl/serial_bit_stream_tx.sv
// Parallel-to-serial transmitter: MSB-first word, then GAP idle cycles, then a done pulse.
// First bit one cycle after the accepting edge; start is ignored while busy (no stall path).
module serial_bit_stream_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_bit_stream_tx_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shreg_q,    shreg_d;
    logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q,  gap_cnt_d;
    logic             prev_one_q, prev_one_d;
    logic             x_out_q,    x_out_d;
    logic             x_valid_q,  x_valid_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    shreg_d   = bus.data_in;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BW'(1);
                if (bit_cnt_q == BW'(WIDTH - 1)) begin
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d   = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d = S_DONE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        x_out_d    = (state_d == S_SHIFT) & shreg_d[WIDTH-1];
        x_valid_d  = (state_d == S_SHIFT);
        busy_d     = (state_d == S_SHIFT) | (state_d == S_GAP);
        done_d     = (state_d == S_DONE);
        prev_one_d = x_out_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            prev_one_q <= 1'b0;
            x_out_q    <= 1'b0;
            x_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            prev_one_q <= prev_one_d;
            x_out_q    <= x_out_d;
            x_valid_q  <= x_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // A 0 following a 1 is exactly what the Mealy zero detector flags.
    assign bus.x_out   = x_out_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.exp_y   = ~x_out_q & prev_one_q;
endmodule

// File: tb/tb_serial_bit_stream_tx.sv
// Bench for serial_bit_stream_tx: three parameterisations, per-cycle scoreboard,
// plus a reference zero detector fed from the WIDTH=8/GAP=1 stream.
module tb_serial_bit_stream_tx;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    serial_bit_stream_tx_if #(.WIDTH(8)) if0 ();
    serial_bit_stream_tx_if #(.WIDTH(8)) if1 ();
    serial_bit_stream_tx_if #(.WIDTH(2)) if2 ();

    serial_bit_stream_tx #(.WIDTH(8), .GAP(1)) u_dut0 (.clock(clock), .reset(reset), .bus(if0));
    serial_bit_stream_tx #(.WIDTH(8), .GAP(0)) u_dut1 (.clock(clock), .reset(reset), .bus(if1));
    serial_bit_stream_tx #(.WIDTH(2), .GAP(3)) u_dut2 (.clock(clock), .reset(reset), .bus(if2));

    typedef struct packed {
        logic [1:0] id;
        logic [4:0] v;   // {x_out, x_valid, busy, done, exp_y}
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_x [3];

    // Reference Mealy zero detector: S1 means the last input was a 1.
    logic det_st;
    logic det_y;
    always @(posedge clock or negedge reset) begin
        if (!reset) det_st <= 1'b0;
        else        det_st <= if0.x_out ? 1'b1 : 1'b0;
    end
    assign det_y = det_st & ~if0.x_out;

    function automatic logic [4:0] actual(input logic [1:0] id);
        case (id)
            2'd0:    return {if0.x_out, if0.x_valid, if0.busy, if0.done, if0.exp_y};
            2'd1:    return {if1.x_out, if1.x_valid, if1.busy, if1.done, if1.exp_y};
            default: return {if2.x_out, if2.x_valid, if2.busy, if2.done, if2.exp_y};
        endcase
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {x,vld,busy,done,y} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    ent_t mon_e;
    always @(negedge clock) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk($sformatf("dut%0d cycle", mon_e.id), actual(mon_e.id), mon_e.v);
        end
        checks++;
        if (det_y !== if0.exp_y) begin
            errors++;
            $display("FAIL detector: y_out got %b expected exp_y %b at %0t", det_y, if0.exp_y, $time);
        end
    end

    // One cycle: push the expected outputs for the cycle just begun, then drive inputs for its closing edge.
    task automatic step(input logic [1:0] id, input bit st, input logic [7:0] dat,
                        input bit x, input bit v, input bit b, input bit d);
        ent_t e;
        @(posedge clock);
        #1;
        e.id = id;
        e.v  = {x, v, b, d, (~x & prev_x[id])};
        q.push_back(e);
        prev_x[id] = x;
        if0.start   = (id == 2'd0) ? st : 1'b0;
        if0.data_in = (id == 2'd0) ? dat : 8'h00;
        if1.start   = (id == 2'd1) ? st : 1'b0;
        if1.data_in = (id == 2'd1) ? dat : 8'h00;
        if2.start   = (id == 2'd2) ? st : 1'b0;
        if2.data_in = (id == 2'd2) ? dat[1:0] : 2'b00;
    endtask

    task automatic idle(input logic [1:0] id, input int n);
        for (int i = 0; i < n; i++) step(id, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Bits MSB-first, GAP zeros, then the done cycle (which may carry the next start).
    task automatic send_word(input logic [1:0] id, input logic [7:0] data, input int w, input int g,
                             input bit intrude, input bit nst, input logic [7:0] ndat);
        logic [7:0] d;
        d = data;
        for (int k = 0; k < w; k++)
            step(id, intrude && (k == 2), 8'h00, d[w-1-k], 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < g; j++)
            step(id, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step(id, nst, ndat, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_x[i] = 1'b0;
        if0.start = 1'b0; if0.data_in = '0;
        if1.start = 1'b0; if1.data_in = '0;
        if2.start = 1'b0; if2.data_in = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("reset dut0", actual(2'd0), 5'b00000);
        chk("reset dut1", actual(2'd1), 5'b00000);
        chk("reset dut2", actual(2'd2), 5'b00000);
        reset = 1'b1;

        // Basic word 8'hB4, GAP=1.
        step(2'd0, 1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(2'd0, 8'hB4, 8, 1, 1'b0, 1'b0, 8'h00);
        idle(2'd0, 3);

        // Back-to-back 8'hFF with GAP=0, restarted from the DONE cycle.
        step(2'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(2'd1, 8'hFF, 8, 0, 1'b0, 1'b1, 8'hFF);
        send_word(2'd1, 8'hFF, 8, 0, 1'b0, 1'b0, 8'h00);
        idle(2'd1, 2);

        // Start with 8'h00 during bit 2 of 8'hA5 must be ignored.
        step(2'd0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(2'd0, 8'hA5, 8, 1, 1'b1, 1'b0, 8'h00);
        idle(2'd0, 4);

        // Asynchronous reset during bit 3 of 8'hF0.
        step(2'd0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        chk("before mid-word reset", actual(2'd0), 5'b11100);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset dut0", actual(2'd0), 5'b00000);
        for (int i = 0; i < 3; i++) prev_x[i] = 1'b0;
        idle(2'd0, 2);
        reset = 1'b1;
        idle(2'd0, 12);

        // Closed loop with the reference detector across four chained words.
        step(2'd0, 1'b1, 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(2'd0, 8'h6D, 8, 1, 1'b0, 1'b1, 8'h00);
        send_word(2'd0, 8'h00, 8, 1, 1'b0, 1'b1, 8'hFF);
        send_word(2'd0, 8'hFF, 8, 1, 1'b0, 1'b1, 8'h81);
        send_word(2'd0, 8'h81, 8, 1, 1'b0, 1'b0, 8'h00);
        idle(2'd0, 2);

        // Narrow word WIDTH=2 with a 3-cycle gap.
        step(2'd2, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(2'd2, 8'h02, 2, 3, 1'b0, 1'b0, 8'h00);
        idle(2'd2, 2);

        @(posedge clock);
        @(posedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
